fft_stream_player: RTL and testbench
====================================

Name: fft_stream_player

Overview:
- Synthesizable stimulus/capture engine for the streaming FFT core.
- Holds complex samples in an internal buffer loaded through a write port, then streams them in frames of N samples with an enable strobe.
- Supports frame count, inter-frame gap and loop mode; monitors the FFT output strobe, indexes output bins and counts completed output frames.
- Replaces file-driven bench stimulus, so the same sequencing runs on hardware and in simulation.

Parameters:
- DATA_WIDTH, 8: width of each I and Q sample.
- N, 256: FFT frame length in samples; power of two.
- DEPTH, 1024: sample buffer entries; power of two, DEPTH >= N.
- GAP_W, 8: width of the inter-frame gap count.
- FRM_W, 16: width of frame counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  buffer write strobe
- wr_addr  in  $clog2(DEPTH)  buffer write address
- wr_data  in  2*DATA_WIDTH  {I[2W-1:W], Q[W-1:0]}
- start  in  1  one-cycle start pulse; honoured only in IDLE
- loop_mode  in  1  1 = replay forever until stop
- stop  in  1  one-cycle pulse; ends the run at the next frame boundary
- num_frames  in  FRM_W  frames to play when loop_mode=0; 0 treated as 1
- gap_cycles  in  GAP_W  idle cycles between frames; 0 = back-to-back
- enable_in  out  1  sample-valid to FFT
- i_out  out  DATA_WIDTH  I sample to FFT
- q_out  out  DATA_WIDTH  Q sample to FFT
- enable_out  in  1  output-valid from FFT
- bin_idx  out  $clog2(N)  index of the current FFT output bin
- frame_done  out  1  pulse on the last bin of each output frame
- frames_out  out  FRM_W  completed output frames since start
- busy  out  1  high from start until DONE
- done  out  1  one-cycle pulse when the run completes
- overrun  out  1  sticky; enable_out seen while IDLE

Behaviour:
- Reset: all outputs 0, FSM to IDLE, read pointer 0, counters 0. Buffer contents are not cleared.
- Reset mid-run aborts immediately. No partial frame is completed.
- Write port works in every state. A write to an address being read returns the old data (read-first).
- start, num_frames, gap_cycles and loop_mode are latched when start is accepted. They are ignored at all other times.
- FSM states: IDLE -> PLAY on start.
- PLAY: one sample per cycle for N cycles.
  - At the end of a frame, go to GAP if gap>0, else stay in PLAY.
  - If this was the last frame, go to DRAIN.
  - Last frame: frames_in == num_frames (loop_mode=0), or stop seen (loop_mode=1 or 0).
- GAP: count gap_cycles cycles with enable_in=0, then return to PLAY.
- DRAIN: wait until frames_out == frames_in, then go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Buffer read is synchronous with 1-cycle latency. enable_in is registered so it aligns exactly with i_out/q_out.
- First enable_in occurs 2 cycles after the start pulse.
- i_out/q_out hold their last value when enable_in=0.
- Read pointer advances once per sample and wraps modulo DEPTH. Frame k therefore starts at (k*N) mod DEPTH.
- Monitor side, active whenever busy=1:
  - bin_idx increments on each enable_out and wraps N-1 -> 0.
  - frame_done is asserted combinationally with enable_out when bin_idx == N-1.
  - frames_out increments on frame_done and saturates at all-ones.
- bin_idx resets to 0 on start.
- enable_out while IDLE sets overrun. overrun is cleared only by rst or start.
- Simultaneous stop and last-sample cycle: the current frame is the last.
- stop in GAP goes to DRAIN without playing another frame.

Decomposition:
- Shared package fft_pkg: DATA_WIDTH/N defaults, state encoding typedef (IDLE, PLAY, GAP, DRAIN, DONE), IQ packing helper constants.
- One sub-module: fft_sample_ram, a simple dual-port RAM (DEPTH x 2*DATA_WIDTH, registered read).
- FSM and monitor stay in the top level.

Test Plan:
- Load buffer[a] = {a[7:0], ~a[7:0]}, N=256, num_frames=1, gap=0; FFT model = fixed delay of 300 cycles.
  -> enable_in high for exactly 256 cycles starting 2 cycles after start; i_out 0..255.
  -> frame_done once; frames_out=1; done pulse; busy drops.
- DEPTH=1024, N=256, num_frames=5, gap=3.
  -> 5 bursts of 256 cycles, each separated by exactly 3 idle cycles.
  -> frame 5 starts at address 0 (wrap); frames_out=5 at done.
- loop_mode=1, stop pulsed during sample 100 of frame 3.
  -> frame 3 completes all 256 samples; no frame 4; DRAIN; done after 3 output frames.
- Reset asserted mid-PLAY at sample 50.
  -> next cycle enable_in=0, busy=0, bin_idx=0, frames_out=0, FSM IDLE.
  -> a new start replays from address 0.
- enable_out pulsed while IDLE.
  -> overrun=1 and stays 1; a following start clears it.
- start pulsed while busy, and num_frames=0.
  -> extra start ignored, run unchanged; num_frames=0 plays exactly one frame.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared defaults and state encoding for the FFT stream player.
// A buffer word packs I in the upper half and Q in the lower half.
package fft_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefN         = 256;
  localparam int unsigned DefDepth     = 1024;
  localparam int unsigned IqLanes      = 2;

  typedef enum logic [2:0] {
    StIdle,
    StPlay,
    StGap,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/fft_sample_ram.sv
// Simple dual-port sample buffer with a registered, read-first read port.
// Contents are never reset; only the read register is.
module fft_sample_ram
  import fft_pkg::*;
#(
  parameter int unsigned Width = IqLanes * DefDataWidth,
  parameter int unsigned Depth = DefDepth,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read data only updates on a read, so the output holds between frames.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_stream_player.sv
// Plays buffered IQ frames into the FFT core and monitors its output strobe,
// counting output bins and completed frames.
module fft_stream_player
  import fft_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned N         = DefN,
  parameter int unsigned Depth     = DefDepth,
  parameter int unsigned GapW      = 8,
  parameter int unsigned FrmW      = 16,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned BinW  = $clog2(N)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_en_i,
  input  logic [AddrW-1:0]             wr_addr_i,
  input  logic [IqLanes*DataWidth-1:0] wr_data_i,
  input  logic                         start_i,
  input  logic                         loop_mode_i,
  input  logic                         stop_i,
  input  logic [FrmW-1:0]              num_frames_i,
  input  logic [GapW-1:0]              gap_cycles_i,
  output logic                         enable_in_o,
  output logic [DataWidth-1:0]         i_out_o,
  output logic [DataWidth-1:0]         q_out_o,
  input  logic                         enable_out_i,
  output logic [BinW-1:0]              bin_idx_o,
  output logic                         frame_done_o,
  output logic [FrmW-1:0]              frames_out_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overrun_o
);

  localparam logic [BinW-1:0] BinMax = BinW'(N - 1);

  state_e state_q, state_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [BinW-1:0]  smp_q, smp_d;
  logic [FrmW-1:0]  nf_q, nf_d;
  logic [FrmW-1:0]  frames_in_q, frames_in_d, frames_in_inc;
  logic [GapW-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic             loop_q, loop_d, stop_q, stop_d;
  logic             en_q;
  logic [BinW-1:0]  bin_q, bin_d;
  logic [FrmW-1:0]  frames_out_q, frames_out_d;
  logic             overrun_q, overrun_d;
  logic             rd_en, last_frame, busy, start_acc, frame_done;
  logic [IqLanes*DataWidth-1:0] rd_data;

  assign busy      = (state_q == StPlay) || (state_q == StGap) || (state_q == StDrain);
  assign start_acc = start_i && (state_q == StIdle);

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    smp_d         = smp_q;
    nf_d          = nf_q;
    frames_in_d   = frames_in_q;
    gap_d         = gap_q;
    gap_cnt_d     = gap_cnt_q;
    loop_d        = loop_q;
    stop_d        = stop_q;
    rd_en         = 1'b0;
    last_frame    = 1'b0;
    frames_in_inc = (frames_in_q == '1) ? frames_in_q : frames_in_q + FrmW'(1);
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StPlay;
          rd_ptr_d    = '0;
          smp_d       = '0;
          frames_in_d = '0;
          nf_d        = (num_frames_i == '0) ? FrmW'(1) : num_frames_i;
          gap_d       = gap_cycles_i;
          loop_d      = loop_mode_i;
          stop_d      = 1'b0;
        end
      end
      StPlay: begin
        rd_en    = 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
        smp_d    = smp_q + 1'b1;
        if (stop_i) begin
          stop_d = 1'b1;
        end
        if (smp_q == BinMax) begin
          frames_in_d = frames_in_inc;
          // A stop arriving on the last sample still ends the run here.
          last_frame  = stop_i || stop_q || (!loop_q && (frames_in_inc == nf_q));
          if (last_frame) begin
            state_d = StDrain;
          end else if (gap_q != '0) begin
            state_d   = StGap;
            gap_cnt_d = gap_q;
          end
        end
      end
      StGap: begin
        if (stop_i || stop_q) begin
          state_d = StDrain;
        end else if (gap_cnt_q == GapW'(1)) begin
          state_d = StPlay;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      StDrain: begin
        if (frames_out_q == frames_in_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    frame_done   = enable_out_i && busy && (bin_q == BinMax);
    bin_d        = bin_q;
    frames_out_d = frames_out_q;
    overrun_d    = overrun_q;
    if (start_acc) begin
      bin_d        = '0;
      frames_out_d = '0;
      overrun_d    = 1'b0;
    end else begin
      if (enable_out_i && busy) begin
        bin_d = frame_done ? '0 : bin_q + 1'b1;
      end
      if (frame_done && (frames_out_q != '1)) begin
        frames_out_d = frames_out_q + FrmW'(1);
      end
      if (enable_out_i && (state_q == StIdle)) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      rd_ptr_q     <= '0;
      smp_q        <= '0;
      nf_q         <= '0;
      frames_in_q  <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      loop_q       <= 1'b0;
      stop_q       <= 1'b0;
      en_q         <= 1'b0;
      bin_q        <= '0;
      frames_out_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      smp_q        <= smp_d;
      nf_q         <= nf_d;
      frames_in_q  <= frames_in_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
      loop_q       <= loop_d;
      stop_q       <= stop_d;
      en_q         <= rd_en;
      bin_q        <= bin_d;
      frames_out_q <= frames_out_d;
      overrun_q    <= overrun_d;
    end
  end

  fft_sample_ram #(
    .Width(IqLanes * DataWidth),
    .Depth(Depth)
  ) u_ram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(rd_data)
  );

  assign enable_in_o  = en_q;
  assign i_out_o      = rd_data[IqLanes*DataWidth-1:DataWidth];
  assign q_out_o      = rd_data[DataWidth-1:0];
  assign bin_idx_o    = bin_q;
  assign frame_done_o = frame_done;
  assign frames_out_o = frames_out_q;
  assign busy_o       = busy;
  assign done_o       = (state_q == StDone);
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_fft_stream_player.sv
// Directed bench: an IQ scoreboard fed at start time, a fixed-latency FFT model,
// and immediate assertions on every comparison.
module tb_fft_stream_player;

  localparam int unsigned NS     = 256;
  localparam int unsigned DEP    = 1024;
  localparam int unsigned BW     = 8;
  localparam int unsigned FftLat = 300;

  typedef struct packed {
    logic        en;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start, loop_mode, stop;
  logic [15:0] num_frames;
  logic [7:0]  gap_cycles;
  logic        enable_in, enable_out;
  logic [7:0]  i_out, q_out;
  logic [7:0]  bin_idx;
  logic        frame_done, busy, done, overrun;
  logic [15:0] frames_out;

  logic [FftLat-1:0] fft_dly;
  logic              ovr_pulse, fft_flush;

  int          checks   = 0;
  int          failures = 0;
  int          fd_cnt   = 0;
  logic [7:0]  exp_bin  = '0;
  bit          sb_active = 1'b0;
  logic [15:0] last_data = '0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  fft_stream_player dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .start_i     (start),
    .loop_mode_i (loop_mode),
    .stop_i      (stop),
    .num_frames_i(num_frames),
    .gap_cycles_i(gap_cycles),
    .enable_in_o (enable_in),
    .i_out_o     (i_out),
    .q_out_o     (q_out),
    .enable_out_i(enable_out),
    .bin_idx_o   (bin_idx),
    .frame_done_o(frame_done),
    .frames_out_o(frames_out),
    .busy_o      (busy),
    .done_o      (done),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  // FFT stand-in: output strobe is the input strobe delayed by FftLat cycles.
  assign enable_out = fft_dly[FftLat-1] | ovr_pulse;
  always @(posedge clk) begin
    if (fft_flush) fft_dly <= '0;
    else           fft_dly <= {fft_dly[FftLat-2:0], enable_in};
  end

  function automatic logic [15:0] buf_word(int a);
    logic [7:0] b;
    b = a[7:0];
    return {b, ~b};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_entry(logic en, logic [15:0] data);
    exp_t e;
    e.en   = en;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_run(int nframes, int gap);
    push_entry(1'b0, last_data);
    for (int f = 0; f < nframes; f++) begin
      for (int j = 0; j < int'(NS); j++) begin
        last_data = buf_word((f * NS + j) % DEP);
        push_entry(1'b1, last_data);
      end
      if (f < nframes - 1) begin
        for (int g = 0; g < gap; g++) push_entry(1'b0, last_data);
      end
    end
    push_entry(1'b0, last_data);
  endtask

  // Pulse start, then scramble the latched inputs to prove they are held.
  task automatic start_run(int nf_in, int gap, bit lp, int frames_exp);
    num_frames = 16'(nf_in);
    gap_cycles = 8'(gap);
    loop_mode  = lp;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    num_frames = 16'd9;
    gap_cycles = 8'd7;
    loop_mode  = ~lp;
    fd_cnt     = 0;
    exp_bin    = '0;
    push_run(frames_exp, gap);
    sb_active  = 1'b1;
  endtask

  task automatic wait_done(string tag, int frames_exp);
    bit seen = 1'b0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_frames_out"}, 32'(frames_out), 32'(frames_exp));
    check({tag, "_frame_done_cnt"}, 32'(fd_cnt), 32'(frames_exp));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; loop_mode = 1'b0; stop = 1'b0;
    num_frames = '0; gap_cycles = '0;
    ovr_pulse = 1'b0; fft_flush = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; fft_flush = 1'b0;
    @(negedge clk);
    check("rst_enable_in", 32'(enable_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_iq", 32'({i_out, q_out}), 32'd0);
    check("rst_frames_out", 32'(frames_out), 32'd0);

    @(posedge clk); #1;
    for (int a = 0; a < int'(DEP); a++) begin
      wr_en = 1'b1; wr_addr = 10'(a); wr_data = buf_word(a);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (sb_active) begin
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("enable_in", 32'(enable_in), 32'(mon_e.en));
            check("iq_out", 32'({i_out, q_out}), 32'(mon_e.data));
          end else begin
            check("enable_in_idle", 32'(enable_in), 32'd0);
          end
        end
        if (enable_out && busy) begin
          check("bin_idx", 32'(bin_idx), 32'(exp_bin));
          check("frame_done", 32'(frame_done), 32'(exp_bin == BW'(NS - 1)));
          exp_bin = (exp_bin == BW'(NS - 1)) ? '0 : exp_bin + 1'b1;
        end
        if (frame_done) fd_cnt++;
      end
    join_none

    // Single frame, back to back.
    start_run(1, 0, 1'b0, 1);
    wait_done("single", 1);

    // Five frames with a 3-cycle gap; the fifth wraps to address 0.
    start_run(5, 3, 1'b0, 5);
    wait_done("gap5", 5);

    // Loop mode, stop during sample 100 of frame 3.
    start_run(1, 0, 1'b1, 3);
    repeat (2 * NS + 100) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_done("loop_stop", 3);

    // Reset mid-play, then replay from address 0.
    start_run(1, 0, 1'b0, 1);
    repeat (51) @(posedge clk);
    #1 rst = 1'b1; fft_flush = 1'b1; sb_active = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0; fft_flush = 1'b0;
    @(negedge clk);
    check("abort_enable_in", 32'(enable_in), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bin_idx", 32'(bin_idx), 32'd0);
    check("abort_frames_out", 32'(frames_out), 32'd0);
    check("abort_iq", 32'({i_out, q_out}), 32'd0);
    last_data = '0;
    @(posedge clk); #1;
    start_run(1, 0, 1'b0, 1);
    wait_done("replay", 1);

    // enable_out while idle sets a sticky overrun.
    @(posedge clk); #1 ovr_pulse = 1'b1;
    @(negedge clk);
    check("idle_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1 ovr_pulse = 1'b0;
    @(negedge clk);
    check("overrun_set", 32'(overrun), 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // num_frames=0 plays one frame; start clears overrun; busy start ignored.
    @(posedge clk); #1;
    start_run(0, 0, 1'b0, 1);
    @(negedge clk);
    check("overrun_cleared", 32'(overrun), 32'd0);
    repeat (100) @(posedge clk);
    #1 num_frames = 16'd4; gap_cycles = 8'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("nf_zero", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
